// File: rtl/relogio_ajuste_ctrl.sv
// Two-button time-set controller: captures HH:MM, steps hours then minutes, commits with LD.
// Define AUTO_REPEAT_EN to enable hold-to-repeat on btn_inc in the edit states.
module relogio_ajuste_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned BLINK_CYC   = 25,
    parameter int unsigned REPEAT_DLY  = 50,
    parameter int unsigned REPEAT_PER  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [1:0] cur_h1,
    input  logic [3:0] cur_h0,
    input  logic [3:0] cur_m1,
    input  logic [3:0] cur_m0,
    output logic       LD,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       edit_hour,
    output logic       edit_min,
    output logic       blink
);

`ifdef AUTO_REPEAT_EN
    localparam bit RepeatEn = 1'b1;
`else
    localparam bit RepeatEn = 1'b0;
`endif

    localparam int unsigned IDLE_W   = $clog2(TIMEOUT_CYC);
    localparam int unsigned BLINK_W  = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam int unsigned HOLD_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);
    localparam logic [HOLD_W-1:0]  DLY_LAST   = HOLD_W'(REPEAT_DLY - 1);
    localparam logic [HOLD_W-1:0]  PER_LAST   = HOLD_W'(REPEAT_PER - 1);

    typedef enum logic [1:0] {StRun, StEditH, StEditM, StCommit} state_e;

    state_e state_q, state_d;

    logic [1:0] mode_sync_q, inc_sync_q;
    logic       mode_prev_q, inc_prev_q;
    logic       mode_ev, inc_ev, inc_any, rep_ev;

    logic [1:0] h1_q, h1_d;
    logic [3:0] h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;

    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [BLINK_W-1:0] bcnt_q, bcnt_d;
    logic               blink_q, blink_d;
    logic               edit_hour_q, edit_min_q;

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              hold_act_q, hold_act_d, hold_arm_q, hold_arm_d;

    logic hour_ok, min_ok, in_edit, entering_edit, next_edit;

    function automatic logic [5:0] hour_inc(input logic [1:0] t, input logic [3:0] u);
        if (t == 2'd2 && u == 4'd3) begin
            return 6'd0;
        end else if (u == 4'd9) begin
            return {t + 2'd1, 4'd0};
        end else begin
            return {t, u + 4'd1};
        end
    endfunction

    function automatic logic [7:0] min_inc(input logic [3:0] t, input logic [3:0] u);
        if (t == 4'd5 && u == 4'd9) begin
            return 8'd0;
        end else if (u == 4'd9) begin
            return {t + 4'd1, 4'd0};
        end else begin
            return {t, u + 4'd1};
        end
    endfunction

    assign mode_ev = mode_sync_q[1] & ~mode_prev_q;
    assign inc_ev  = inc_sync_q[1] & ~inc_prev_q;

    // Repeat fires after REPEAT_DLY cycles of hold, then every REPEAT_PER cycles.
    assign rep_ev  = RepeatEn & hold_act_q & inc_sync_q[1] &
                     (hold_q == (hold_arm_q ? PER_LAST : DLY_LAST));
    assign inc_any = inc_ev | rep_ev;

    assign hour_ok = (cur_h0 <= 4'd9) &&
                     ((cur_h1 < 2'd2) || (cur_h1 == 2'd2 && cur_h0 <= 4'd3));
    assign min_ok  = (cur_m1 <= 4'd5) && (cur_m0 <= 4'd9);

    assign in_edit       = (state_q == StEditH) || (state_q == StEditM);
    assign next_edit     = (state_d == StEditH) || (state_d == StEditM);
    assign entering_edit = next_edit && (state_d != state_q);

    always_comb begin
        state_d = state_q;
        h1_d    = h1_q;
        h0_d    = h0_q;
        m1_d    = m1_q;
        m0_d    = m0_q;
        idle_d  = idle_q;
        unique case (state_q)
            StRun: begin
                idle_d = '0;
                if (mode_ev) begin
                    {h1_d, h0_d} = hour_ok ? {cur_h1, cur_h0} : 6'd0;
                    {m1_d, m0_d} = min_ok ? {cur_m1, cur_m0} : 8'd0;
                    state_d      = StEditH;
                end
            end
            StEditH: begin
                if (mode_ev) begin
                    state_d = StEditM;
                    idle_d  = '0;
                end else if (inc_any) begin
                    {h1_d, h0_d} = hour_inc(h1_q, h0_q);
                    idle_d       = '0;
                end else if (idle_q == IDLE_LAST) begin
                    state_d = StRun;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            StEditM: begin
                if (mode_ev) begin
                    state_d = StCommit;
                    idle_d  = '0;
                end else if (inc_any) begin
                    {m1_d, m0_d} = min_inc(m1_q, m0_q);
                    idle_d       = '0;
                end else if (idle_q == IDLE_LAST) begin
                    state_d = StRun;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            StCommit: begin
                idle_d  = '0;
                state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        bcnt_d  = '0;
        blink_d = 1'b0;
        if (entering_edit) begin
            blink_d = 1'b1;
        end else if (next_edit) begin
            if (bcnt_q == BLINK_LAST) begin
                blink_d = ~blink_q;
            end else begin
                bcnt_d  = bcnt_q + BLINK_W'(1);
                blink_d = blink_q;
            end
        end
    end

    always_comb begin
        hold_d     = hold_q;
        hold_act_d = hold_act_q;
        hold_arm_d = hold_arm_q;
        if (!RepeatEn || (state_d != state_q) || !inc_sync_q[1] || !in_edit) begin
            hold_d     = '0;
            hold_act_d = 1'b0;
            hold_arm_d = 1'b0;
        end else if (inc_ev) begin
            hold_d     = '0;
            hold_act_d = 1'b1;
            hold_arm_d = 1'b0;
        end else if (hold_act_q) begin
            if (rep_ev) begin
                hold_d     = '0;
                hold_arm_d = 1'b1;
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StRun;
            mode_sync_q <= '0;
            inc_sync_q  <= '0;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
            h1_q        <= '0;
            h0_q        <= '0;
            m1_q        <= '0;
            m0_q        <= '0;
            idle_q      <= '0;
            bcnt_q      <= '0;
            blink_q     <= 1'b0;
            edit_hour_q <= 1'b0;
            edit_min_q  <= 1'b0;
            hold_q      <= '0;
            hold_act_q  <= 1'b0;
            hold_arm_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_sync_q <= {mode_sync_q[0], btn_mode};
            inc_sync_q  <= {inc_sync_q[0], btn_inc};
            mode_prev_q <= mode_sync_q[1];
            inc_prev_q  <= inc_sync_q[1];
            h1_q        <= h1_d;
            h0_q        <= h0_d;
            m1_q        <= m1_d;
            m0_q        <= m0_d;
            idle_q      <= idle_d;
            bcnt_q      <= bcnt_d;
            blink_q     <= blink_d;
            edit_hour_q <= (state_d == StEditH);
            edit_min_q  <= (state_d == StEditM);
            hold_q      <= hold_d;
            hold_act_q  <= hold_act_d;
            hold_arm_q  <= hold_arm_d;
        end
    end

    assign LD        = (state_q == StCommit);
    assign H_in1     = h1_q;
    assign H_in0     = h0_q;
    assign M_in1     = m1_q;
    assign M_in0     = m0_q;
    assign edit_hour = edit_hour_q;
    assign edit_min  = edit_min_q;
    assign blink     = blink_q;

endmodule

// File: tb/tb_relogio_ajuste_ctrl.sv
// Randomized bench for relogio_ajuste_ctrl against a time-based behavioural model.
module tb_relogio_ajuste_ctrl;

    localparam int T   = 40;
    localparam int B   = 5;
    localparam int DLY = 12;
    localparam int PER = 4;
`ifdef AUTO_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0, btn_inc = 1'b0;
    logic [1:0] cur_h1 = '0;
    logic [3:0] cur_h0 = '0, cur_m1 = '0, cur_m0 = '0;
    logic       LD, edit_hour, edit_min, blink;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic [13:0] hm_obs;

    relogio_ajuste_ctrl #(
        .TIMEOUT_CYC(T), .BLINK_CYC(B), .REPEAT_DLY(DLY), .REPEAT_PER(PER)
    ) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
        .LD(LD), .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .edit_hour(edit_hour), .edit_min(edit_min), .blink(blink)
    );

    assign hm_obs = {H_in1, H_in0, M_in1, M_in0};

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int ld_seen = 0;

    // Model: mode 0=run 1=hour 2=minute 3=commit; time held as plain integers.
    int m_mode, m_hh, m_mm, m_idle, m_age, m_k;
    bit m_act;
    bit hm [3];
    bit hi [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int hm_exp(input int hh, input int mm);
        return ((hh / 10) << 12) | ((hh % 10) << 8) | ((mm / 10) << 4) | (mm % 10);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_hh = 0; m_mm = 0; m_idle = 0; m_age = 0; m_k = 0; m_act = 0;
        for (int j = 0; j < 3; j++) begin
            hm[j] = 0;
            hi[j] = 0;
        end
    endtask

    task automatic model_advance(input bit m, input bit i);
        bit me, ie, rep;
        int prev, hv, mv;
        me   = hm[1] && !hm[2];
        ie   = hi[1] && !hi[2];
        rep  = 0;
        prev = m_mode;
        if (REP && m_act && (m_mode == 1 || m_mode == 2)) begin
            if (!hi[1]) m_act = 0;
            else begin
                m_k++;
                rep = (m_k == DLY) || (m_k > DLY && (m_k - DLY) % PER == 0);
            end
        end
        case (m_mode)
            0: if (me) begin
                hv = int'(cur_h1) * 10 + int'(cur_h0);
                mv = int'(cur_m1) * 10 + int'(cur_m0);
                m_hh = (cur_h0 <= 9 && hv <= 23) ? hv : 0;
                m_mm = (cur_m0 <= 9 && mv <= 59) ? mv : 0;
                m_mode = 1;
            end
            1, 2: begin
                if (me) m_mode = m_mode + 1;
                else if (ie || rep) begin
                    if (m_mode == 1) m_hh = (m_hh + 1) % 24;
                    else m_mm = (m_mm + 1) % 60;
                    m_idle = 0;
                    m_age++;
                end else if (m_idle == T - 1) m_mode = 0;
                else begin
                    m_idle++;
                    m_age++;
                end
            end
            default: m_mode = 0;
        endcase
        if (m_mode != prev) begin
            m_idle = 0;
            m_age  = 0;
            m_act  = 0;
        end else if (ie && (m_mode == 1 || m_mode == 2)) begin
            m_act = REP;
            m_k   = 0;
        end
        hm[2] = hm[1]; hm[1] = hm[0]; hm[0] = m;
        hi[2] = hi[1]; hi[1] = hi[0]; hi[0] = i;
    endtask

    task automatic compare_all();
        bit ed;
        ed = (m_mode == 1 || m_mode == 2);
        check("ld", 32'(LD), 32'(m_mode == 3));
        check("hm", 32'(hm_obs), 32'(hm_exp(m_hh, m_mm)));
        check("edit_hour", 32'(edit_hour), 32'(m_mode == 1));
        check("edit_min", 32'(edit_min), 32'(m_mode == 2));
        check("blink", 32'(blink), 32'(ed && ((m_age / B) % 2 == 0)));
    endtask

    // Called at a negedge: drive, advance the model over the next posedge, compare at next negedge.
    task automatic step(input bit m, input bit i);
        btn_mode = m;
        btn_inc  = i;
        model_advance(m, i);
        @(negedge clk);
        compare_all();
        if (LD === 1'b1) ld_seen++;
    endtask

    task automatic press(input bit m, input bit i);
        step(m, i); step(m, i);
        repeat (4) step(0, 0);
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ld", 32'(LD), 32'd0);
        check("rst_hm", 32'(hm_obs), 32'd0);
        check("rst_edit", 32'({edit_hour, edit_min, blink}), 32'd0);
        reset = 1'b0;
        model_reset();
        ld_seen = 0;
    endtask

    task automatic set_cur(input int h1, input int h0, input int m1, input int m0);
        cur_h1 = 2'(h1); cur_h0 = 4'(h0); cur_m1 = 4'(m1); cur_m0 = 4'(m0);
    endtask

    initial begin
        bit bm, bi;
        int quiet;
        model_reset();
        apply_reset();

        // Mode event shows up as edit_hour three edges after the rise.
        step(1, 0); step(1, 0);
        check("enter_e2", 32'(edit_hour), 32'd0);
        step(0, 0);
        check("enter_e3", 32'(edit_hour), 32'd1);
        repeat (4) step(0, 0);

        // 23:59 wraps to 00:00.
        apply_reset();
        set_cur(2, 3, 5, 9);
        press(1, 0); press(0, 1); press(1, 0); press(0, 1); press(1, 0);
        repeat (3) step(0, 0);
        check("wrap_ld_count", 32'(ld_seen), 32'd1);
        check("wrap_hm", 32'(hm_obs), 32'd0);

        // 09:09 carries to 10:10.
        apply_reset();
        set_cur(0, 9, 0, 9);
        press(1, 0); press(0, 1); press(1, 0); press(0, 1); press(1, 0);
        repeat (3) step(0, 0);
        check("carry_ld_count", 32'(ld_seen), 32'd1);
        check("carry_hm", 32'(hm_obs), 32'h1010);

        // Invalid hour 27 loads 00, minutes kept.
        apply_reset();
        set_cur(2, 7, 4, 5);
        press(1, 0); press(1, 0); press(1, 0);
        repeat (3) step(0, 0);
        check("clamp_ld_count", 32'(ld_seen), 32'd1);
        check("clamp_hm", 32'(hm_obs), 32'h0045);

        // Inactivity timeout abandons the edit without LD.
        apply_reset();
        set_cur(1, 5, 3, 0);
        press(1, 0);
        check("to_in_edit", 32'(edit_hour), 32'd1);
        repeat (T + 5) step(0, 0);
        check("to_edit_hour", 32'(edit_hour), 32'd0);
        check("to_ld_count", 32'(ld_seen), 32'd0);

        // Simultaneous mode+inc: mode wins, hour unchanged.
        apply_reset();
        set_cur(1, 2, 3, 4);
        press(1, 0);
        press(1, 1);
        check("simul_edit_min", 32'(edit_min), 32'd1);
        check("simul_hour", 32'({H_in1, H_in0}), 32'h12);
        press(1, 0);
        repeat (3) step(0, 0);
        check("simul_ld_count", 32'(ld_seen), 32'd1);

        // Reset mid-edit: no partial commit.
        apply_reset();
        set_cur(0, 8, 1, 1);
        press(1, 0); press(0, 1); press(1, 0);
        apply_reset();
        repeat (5) step(0, 0);
        check("midrst_ld_count", 32'(ld_seen), 32'd0);

`ifdef AUTO_REPEAT_EN
        // Hold inc in EDIT_M from 00: one edge event plus two repeats.
        apply_reset();
        set_cur(0, 0, 0, 0);
        press(1, 0); press(1, 0);
        repeat (DLY + 2 * PER) step(0, 1);
        repeat (5) step(0, 0);
        check("repeat_min", 32'({M_in1, M_in0}), 32'h03);
`endif

        // Randomized run, model checked every cycle.
        apply_reset();
        bm = 0; bi = 0; quiet = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 97 == 0)
                set_cur($urandom_range(0, 3), $urandom_range(0, 11),
                        $urandom_range(0, 7), $urandom_range(0, 11));
            if (c == 2000) apply_reset();
            if (quiet > 0) begin
                quiet--;
                bm = 0;
                bi = ($urandom_range(0, 1) == 1) ? bi : 1'b0;
            end else begin
                if ($urandom_range(0, 99) < 3) quiet = $urandom_range(20, 60);
                if ($urandom_range(0, 99) < 15) bm = ~bm;
                if ($urandom_range(0, 99) < 20) bi = ~bi;
            end
            step(bm, bi);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
